// File: rtl/tail_light_sequencer_pkg.sv
// Shared state and direction encodings for the tail-light sequencer.
package tail_light_sequencer_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TURN   = 2'd1;
   localparam logic [1:0] ST_HAZARD = 2'd2;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/tail_tick_gen.sv
// Step-rate prescaler: one-cycle tick every TICK_DIV clocks, restartable through clear.
module tail_tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/tail_light_sequencer.sv
// Turn/hazard/brake tail-light controller: N_LAMPS per side, prescaled stepping,
// synchronised board inputs and registered lamp outputs.
module tail_light_sequencer #(
   parameter int N_LAMPS  = 3,
   parameter int TICK_DIV = 5000000,
   parameter int SYNC_FF  = 2
) (
   input  logic               ADC_CLK_10,
   input  logic               reset_n,
   input  logic               sel_n,
   input  logic               turn_en,
   input  logic               hazard,
   input  logic               brake,
   output logic [N_LAMPS-1:0] left_o,
   output logic [N_LAMPS-1:0] right_o,
   output logic               dir_o
);
   import tail_light_sequencer_pkg::*;

   localparam int SW = $clog2(N_LAMPS + 1);
   localparam logic [SW-1:0]      STEP_MAX = SW'(N_LAMPS);
   localparam logic [N_LAMPS-1:0] ALL_ON   = '1;

   logic [1:0]              rst_q;
   logic                    rst_n_i;
   logic [SYNC_FF-1:0][3:0] sync_q;
   logic                    sel_s, turn_s, haz_s, brake_s, sel_prev;
   logic [1:0]              state, state_nxt;
   logic [SW-1:0]           step, step_nxt;
   logic                    phase, phase_nxt, dir_nxt;
   logic                    sel_fall, restart, tick;
   logic [N_LAMPS-1:0]      side, active, left_nxt, right_nxt;

   function automatic logic [N_LAMPS-1:0] thermo(input logic [SW-1:0] s);
      logic [N_LAMPS-1:0] t;
      t = '0;
      for (int i = 0; i < N_LAMPS; i++) begin
         t[i] = (i < int'(s));
      end
      return t;
   endfunction

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
         rst_q <= 2'b00;
      end else begin
         rst_q <= {rst_q[0], 1'b1};
      end
   end
   assign rst_n_i = rst_q[1];

   assign {brake_s, haz_s, turn_s, sel_s} = sync_q[SYNC_FF-1];

   tail_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (ADC_CLK_10),
      .rst_n (rst_n_i),
      .clear (restart),
      .tick  (tick)
   );

   always_comb begin
      sel_fall  = sel_prev & ~sel_s;
      state_nxt = haz_s ? ST_HAZARD : (turn_s ? ST_TURN : ST_IDLE);
      restart   = (state_nxt != state) || sel_fall;
      dir_nxt   = sel_fall ? ~dir_o : dir_o;
      step_nxt  = '0;
      phase_nxt = 1'b0;
      if (!restart) begin
         if (state_nxt == ST_TURN) begin
            step_nxt = tick ? ((step == STEP_MAX) ? '0 : step + 1'b1) : step;
         end
         if (state_nxt == ST_HAZARD) begin
            phase_nxt = tick ? ~phase : phase;
         end
      end
      // Outputs are decoded from next-cycle values so they land with the state update.
      side      = brake_s ? ALL_ON : '0;
      active    = thermo(step_nxt);
      left_nxt  = side;
      right_nxt = side;
      case (state_nxt)
         ST_TURN: begin
            if (dir_nxt == DIR_RIGHT) begin
               right_nxt = active;
            end else begin
               left_nxt = active;
            end
         end
         ST_HAZARD: begin
            left_nxt  = phase_nxt ? ALL_ON : '0;
            right_nxt = phase_nxt ? ALL_ON : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ADC_CLK_10 or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q   <= {SYNC_FF{4'b0001}};
         sel_prev <= 1'b1;
         state    <= ST_IDLE;
         step     <= '0;
         phase    <= 1'b0;
         dir_o    <= DIR_LEFT;
         left_o   <= '0;
         right_o  <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_FF-2:0], brake, hazard, turn_en, sel_n};
         sel_prev <= sel_s;
         state    <= state_nxt;
         step     <= step_nxt;
         phase    <= phase_nxt;
         dir_o    <= dir_nxt;
         left_o   <= left_nxt;
         right_o  <= right_nxt;
      end
   end
endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: directed table, hand-written corner sequences
// and randomized stimulus against a cycle-count based reference model.
module tb_tail_light_sequencer;
   localparam int N  = 3;
   localparam int TD = 2;
   localparam int SF = 2;

   logic         clk = 1'b0;
   logic         reset_n, sel_n, turn_en, hazard, brake;
   logic [N-1:0] left_o, right_o;
   logic         dir_o;

   int n_checks = 0;
   int n_errors = 0;

   tail_light_sequencer #(
      .N_LAMPS  (N),
      .TICK_DIV (TD),
      .SYNC_FF  (SF)
   ) dut (
      .ADC_CLK_10 (clk),
      .reset_n    (reset_n),
      .sel_n      (sel_n),
      .turn_en    (turn_en),
      .hazard     (hazard),
      .brake      (brake),
      .left_o     (left_o),
      .right_o    (right_o),
      .dir_o      (dir_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic sel;
      logic turn;
      logic haz;
      logic brk;
   } in_t;

   typedef struct {
      logic         turn;
      logic         haz;
      logic         brk;
      logic         sel;
      logic [N-1:0] left;
      logic [N-1:0] right;
      logic         dir;
   } vec_t;

   // Reference model: mode, direction and cycles elapsed since the last restart.
   in_t          hist[$];
   int           m_mode, m_age, m_rel;
   logic         m_dir, m_prev_sel;
   logic [N-1:0] m_left, m_right;

   function automatic logic [N-1:0] bar(input int k);
      logic [31:0] v;
      v = (32'd1 << k) - 32'd1;
      return v[N-1:0];
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < SF; i++) hist.push_back(in_t'(4'b1000));
      m_mode = 0; m_age = 0; m_dir = 1'b0; m_prev_sel = 1'b1;
      m_left = '0; m_right = '0;
   endtask

   task automatic model_step(input in_t cur);
      in_t  d;
      int   m, k;
      logic fall;
      hist.push_back(cur);
      d = hist.pop_front();
      fall = m_prev_sel && !d.sel;
      m_prev_sel = d.sel;
      m = d.haz ? 2 : (d.turn ? 1 : 0);
      if (fall) m_dir = !m_dir;
      if (fall || m != m_mode) m_age = 0; else m_age++;
      m_mode = m;
      k = m_age / TD;
      m_left  = {N{d.brk}};
      m_right = {N{d.brk}};
      if (m == 1) begin
         if (m_dir) m_right = bar(k % (N + 1));
         else       m_left  = bar(k % (N + 1));
      end else if (m == 2) begin
         m_left  = {N{(k % 2) == 1}};
         m_right = {N{(k % 2) == 1}};
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
         m_rel = 0;
      end else if (m_rel < 2) begin
         m_rel++;
      end else begin
         model_step(in_t'{sel: sel_n, turn: turn_en, haz: hazard, brk: brake});
      end
      #1;
   endtask

   task automatic cmp_model(input string tag);
      check({tag, "_left"},  32'(left_o),  32'(m_left));
      check({tag, "_right"}, 32'(right_o), 32'(m_right));
      check({tag, "_dir"},   32'(dir_o),   32'(m_dir));
   endtask

   task automatic cycle_chk(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         cycle();
         cmp_model(tag);
      end
   endtask

   vec_t         tbl[20];
   logic [N-1:0] tab_left [20];
   logic [N-1:0] tab_right[20];

   initial begin
      tab_left  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7,
                    3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7};
      tab_right = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                    3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
      for (int r = 0; r < 20; r++) begin
         tbl[r].turn  = (r < 16);
         tbl[r].haz   = 1'b0;
         tbl[r].brk   = (r >= 12);
         tbl[r].sel   = 1'b1;
         tbl[r].left  = tab_left[r];
         tbl[r].right = tab_right[r];
         tbl[r].dir   = 1'b0;
      end

      // Reset held with hazard requested: everything stays dark.
      reset_n = 1'b0; sel_n = 1'b1; turn_en = 1'b0; hazard = 1'b1; brake = 1'b0;
      model_reset(); m_rel = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("rst_left",  32'(left_o),  32'd0);
         check("rst_right", 32'(right_o), 32'd0);
         check("rst_dir",   32'(dir_o),   32'd0);
      end
      reset_n = 1'b1;
      cycle_chk("haz_after_rst", 12);
      hazard = 1'b0;
      cycle_chk("idle", 8);

      // Left turn, then brake, then turn released.
      for (int r = 0; r < 20; r++) begin
         turn_en = tbl[r].turn; hazard = tbl[r].haz; brake = tbl[r].brk; sel_n = tbl[r].sel;
         cycle();
         check($sformatf("tbl%0d_left", r),  32'(left_o),  32'(tbl[r].left));
         check($sformatf("tbl%0d_right", r), 32'(right_o), 32'(tbl[r].right));
         check($sformatf("tbl%0d_dir", r),   32'(dir_o),   32'(tbl[r].dir));
      end

      // Direction toggle mid-sequence restarts on the right side.
      brake = 1'b0; turn_en = 1'b1;
      cycle_chk("seqB", 9);
      sel_n = 1'b0;
      cycle();
      sel_n = 1'b1;
      cycle(); cycle();
      check("sel_dir",   32'(dir_o),   32'd1);
      check("sel_left",  32'(left_o),  32'd0);
      check("sel_right", 32'(right_o), 32'd0);
      cycle(); cycle();
      check("sel_right_step1", 32'(right_o), 32'd1);
      cmp_model("seqB_model");

      // Brake during right turn, hazard override, hazard release.
      brake = 1'b1;
      cycle_chk("seqC", 4);
      check("brk_left", 32'(left_o), 32'd7);
      hazard = 1'b1;
      cycle(); cycle(); cycle();
      check("haz_off_left",  32'(left_o),  32'd0);
      check("haz_off_right", 32'(right_o), 32'd0);
      cycle(); cycle();
      check("haz_on_left",  32'(left_o),  32'd7);
      check("haz_on_right", 32'(right_o), 32'd7);
      hazard = 1'b0;
      cycle(); cycle(); cycle();
      check("resume_right", 32'(right_o), 32'd0);
      check("resume_left",  32'(left_o),  32'd7);
      cycle(); cycle();
      check("resume_right_step1", 32'(right_o), 32'd1);
      turn_en = 1'b0;
      cycle(); cycle(); cycle();
      check("brk_idle_left",  32'(left_o),  32'd7);
      check("brk_idle_right", 32'(right_o), 32'd7);
      cmp_model("seqC_model");

      // Asynchronous reset mid-activity.
      reset_n = 1'b0;
      model_reset(); m_rel = 0;
      #1;
      check("async_left",  32'(left_o),  32'd0);
      check("async_right", 32'(right_o), 32'd0);
      check("async_dir",   32'(dir_o),   32'd0);
      brake = 1'b0;
      cycle_chk("in_rst", 3);
      reset_n = 1'b1;
      cycle_chk("post_rst", 6);

      // Hazard, turn and direction toggle arriving together.
      hazard = 1'b1; turn_en = 1'b1; sel_n = 1'b0;
      cycle();
      sel_n = 1'b1;
      cycle(); cycle();
      check("simul_dir",   32'(dir_o),   32'd1);
      check("simul_left",  32'(left_o),  32'd0);
      check("simul_right", 32'(right_o), 32'd0);
      cycle(); cycle();
      check("simul_on_left",  32'(left_o),  32'd7);
      check("simul_on_right", 32'(right_o), 32'd7);
      hazard = 1'b0; turn_en = 1'b0;
      cycle_chk("settle", 4);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) turn_en = ~turn_en;
         if ($urandom_range(59) == 0) hazard  = ~hazard;
         if ($urandom_range(29) == 0) brake   = ~brake;
         if (!sel_n) begin
            if ($urandom_range(2) == 0) sel_n = 1'b1;
         end else if ($urandom_range(49) == 0) begin
            sel_n = 1'b0;
         end
         cycle_chk("rand", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
